downsample_avg2x2: RTL and testbench

DOWNSAMPLE_AVG2X2 -- requirements
Module: downsample_avg2x2

---
 rtl/downsample_avg2x2_if.sv | 23 ++
 rtl/downsample_avg2x2.sv | 100 ++++++++++
 tb/tb_downsample_avg2x2.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/downsample_avg2x2_if.sv
// rtl/downsample_avg2x2_if.sv - job control plus input/output memory ports of the 2x2 averaging downsampler
interface downsample_avg2x2_if #(
  parameter int length = 16
);
  logic              start;
  logic [2:0]        size_downsample;
  logic              done;
  logic [length-1:0] t_data_in;
  logic [13:0]       addr_input;
  logic [length-1:0] t_data_out;
  logic              en_write_out;
  logic [13:0]       addr_output;

  modport slave (
    input  start, size_downsample, t_data_in,
    output done, addr_input, t_data_out, en_write_out, addr_output
  );

  modport master (
    output start, size_downsample, t_data_in,
    input  done, addr_input, t_data_out, en_write_out, addr_output
  );
endinterface

// File: rtl/downsample_avg2x2.sv
// rtl/downsample_avg2x2.sv - averages each 2x2 block of a WxW signed map into a (W/2)x(W/2) map
module downsample_avg2x2 #(
  parameter int length = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  downsample_avg2x2_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          size_q;
  logic [2:0]          phase;
  logic [5:0]          r, c;
  logic signed [length+1:0] acc;
  logic [length+1:0]   ext, sum;
  logic [13:0]         addr_hold, rd_addr, wr_addr;
  logic [6:0]          half_m1, row, col;
  logic                last_col, last_pixel;

  // Read address of the current tap: phase bit 1 picks the lower row, bit 0 the right column.
  always_comb begin
    half_m1    = (7'd2 << size_q) - 7'd1;
    last_col   = ({1'b0, c} == half_m1);
    last_pixel = last_col && ({1'b0, r} == half_m1) && (phase == 3'd4);
    row        = {r, 1'b0} | {6'b0, phase[1]};
    col        = {c, 1'b0} | {6'b0, phase[0]};
    rd_addr    = (({7'b0, row} << size_q) << 2) | {7'b0, col};
    wr_addr    = (({8'b0, r} << size_q) << 1) | {8'b0, c};
    ext        = {{2{bus.t_data_in[length-1]}}, bus.t_data_in};
    sum        = acc + ext;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = (bus.size_downsample <= 3'd5) ? RUN : DONE;
      RUN:   if (last_pixel) state_nxt = FLUSH;
      FLUSH: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase 4 issues no read, so the address bus keeps showing the last tap fetched.
  always_comb begin
    bus.done       = (state == DONE);
    bus.addr_input = (state == RUN && phase != 3'd4) ? rd_addr : addr_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q           <= 3'd0;
      phase            <= 3'd0;
      r                <= 6'd0;
      c                <= 6'd0;
      acc              <= '0;
      addr_hold        <= 14'd0;
      bus.t_data_out   <= '0;
      bus.en_write_out <= 1'b0;
      bus.addr_output  <= 14'd0;
    end else begin
      bus.en_write_out <= 1'b0;
      addr_hold        <= bus.addr_input;
      if (state == IDLE && bus.start) begin
        size_q <= bus.size_downsample;
        phase  <= 3'd0;
        r      <= 6'd0;
        c      <= 6'd0;
      end
      if (state == RUN) begin
        case (phase)
          3'd1: acc <= ext;
          3'd2, 3'd3: acc <= sum;
          3'd4: begin
            acc              <= sum;
            bus.t_data_out   <= sum[length+1:2];
            bus.en_write_out <= 1'b1;
            bus.addr_output  <= wr_addr;
            if (last_col) begin
              c <= 6'd0;
              r <= r + 6'd1;
            end else begin
              c <= c + 6'd1;
            end
          end
          default: ;
        endcase
        phase <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_downsample_avg2x2.sv
// tb/tb_downsample_avg2x2.sv - directed bench for downsample_avg2x2 with a 1-cycle-latency input memory
module tb_downsample_avg2x2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] mem [0:16383];
  logic [13:0] wa [$];
  logic [15:0] wd [$];

  downsample_avg2x2_if #(.length(16)) bus ();

  downsample_avg2x2 #(.length(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.t_data_in <= mem[bus.addr_input];

  always @(negedge clk) begin
    if (bus.en_write_out) begin
      wa.push_back(bus.addr_output);
      wd.push_back(bus.t_data_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input logic [2:0] sz, input int limit, output int cyc);
    bus.size_downsample = sz;
    bus.start = 1'b1;
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
      if (bus.done) break;
    end
  endtask

  task automatic check_map(input int sz, input string tag);
    int w, half, n, nerr, s, base;
    logic [15:0] e;
    w = 4 << sz;
    half = w / 2;
    n = half * half;
    nerr = 0;
    chk({tag, "_nwrites"}, wa.size(), n);
    for (int k = 0; k < n && k < wa.size(); k++) begin
      base = 2 * (k / half) * w + 2 * (k % half);
      s = int'($signed(mem[base])) + int'($signed(mem[base+1]))
        + int'($signed(mem[base+w])) + int'($signed(mem[base+w+1]));
      e = 16'(s >>> 2);
      if (wa[k] !== 14'(k) || wd[k] !== e) nerr++;
    end
    chk({tag, "_data"}, nerr, 0);
  endtask

  initial begin
    int cyc;
    int done_seen;
    logic [13:0] a_before;
    logic [15:0] tap [0:15];

    rst = 1'b1;
    bus.start = 1'b0;
    bus.size_downsample = 3'd0;
    for (int i = 0; i < 16384; i++) mem[i] = 16'(i);
    repeat (3) @(negedge clk);
    chk("rst_done", bus.done, 0);
    chk("rst_en", bus.en_write_out, 0);
    chk("rst_dout", bus.t_data_out, 0);
    chk("rst_ain", bus.addr_input, 0);
    chk("rst_aout", bus.addr_output, 0);
    rst = 1'b0;
    @(negedge clk);

    // W=4, input[i]=i
    wa.delete(); wd.delete();
    run_job(3'd0, 100, cyc);
    chk("w4_cycles", cyc, 22);
    chk("w4_nwr", wa.size(), 4);
    if (wa.size() == 4) begin
      chk("w4_a0", wa[0], 0); chk("w4_d0", wd[0], 16'd2);
      chk("w4_a1", wa[1], 1); chk("w4_d1", wd[1], 16'd4);
      chk("w4_a2", wa[2], 2); chk("w4_d2", wd[2], 16'd10);
      chk("w4_a3", wa[3], 3); chk("w4_d3", wd[3], 16'd12);
    end
    @(negedge clk);

    // Rounding and extreme taps, one 2x2 block per output pixel
    tap = '{16'd1, 16'd2, 16'hFFFF, 16'hFFFF,
            16'd3, 16'd4, 16'hFFFF, 16'hFFFE,
            16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000,
            16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    for (int i = 0; i < 16; i++) mem[i] = tap[i];
    wa.delete(); wd.delete();
    run_job(3'd0, 100, cyc);
    chk("rnd_nwr", wa.size(), 4);
    if (wa.size() == 4) begin
      chk("rnd_pos", wd[0], 16'h0002);
      chk("rnd_neg", wd[1], 16'hFFFE);
      chk("rnd_max", wd[2], 16'h7FFF);
      chk("rnd_min", wd[3], 16'h8000);
    end
    @(negedge clk);

    // W=128, random data
    for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
    wa.delete(); wd.delete();
    run_job(3'd5, 30000, cyc);
    chk("w128_cycles", cyc, 20482);
    chk("w128_last_rd", bus.addr_input, 16383);
    check_map(5, "w128");
    @(negedge clk);

    // Invalid size: straight to DONE, no reads or writes
    wa.delete(); wd.delete();
    a_before = bus.addr_input;
    run_job(3'd6, 10, cyc);
    chk("inv_cycles", cyc, 1);
    chk("inv_nwr", wa.size(), 0);
    chk("inv_ain", bus.addr_input, a_before);
    @(negedge clk);

    // Reset in phase 2 of pixel 1 at W=8
    wa.delete(); wd.delete();
    bus.size_downsample = 3'd1;
    bus.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    chk("abort_pre_nwr", wa.size(), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_en", bus.en_write_out, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_dout", bus.t_data_out, 0);
    chk("abort_ain", bus.addr_input, 0);
    chk("abort_aout", bus.addr_output, 0);
    done_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_no_wr", wa.size(), 1);
    wa.delete(); wd.delete();
    run_job(3'd1, 200, cyc);
    chk("w8_cycles", cyc, 82);
    check_map(1, "w8");
    @(negedge clk);

    // start held high, size changed mid-job
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    wa.delete(); wd.delete();
    bus.size_downsample = 3'd0;
    bus.start = 1'b1;
    cyc = 0;
    done_seen = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) bus.size_downsample = 3'd3;
      if (bus.done) break;
    end
    chk("hold_cycles", cyc, 22);
    check_map(0, "hold");
    wa.delete(); wd.delete();
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 24) bus.start = 1'b0;
      if (bus.done) break;
    end
    chk("hold2_cycles", cyc, 1305);
    chk("hold2_nwr", wa.size(), 256);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
